// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO, decodes frames for phy_addr, drives register strobes.
// Bits are sampled and drive values change only on the clk cycle of a synchronised MDC rise.
module mdio_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int RD_LATENCY    = 2,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_rx_data,
  output logic        mdio_tx_data,
  output logic        mdio_tx_en,
  input  logic [4:0]  phy_addr,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr,
  output logic [15:0] reg_wr_data,
  output logic        frame_err
);

  typedef enum logic [3:0] {
    S_PRE, S_ST1, S_OP, S_ADDR, S_TA1, S_TA2, S_RD, S_REND, S_WTA, S_WD, S_SKIP
  } state_t;

  localparam logic [5:0] PB      = 6'(PREAMBLE_BITS);
  localparam logic [3:0] RD_LAT4 = 4'(RD_LATENCY);

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
  logic        mdc_prev_q;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d;
  logic        is_rd_q, is_rd_d;
  logic [15:0] rd_sh_q, rd_sh_d;
  logic [3:0]  lat_q, lat_d;
  logic        tx_en_q, tx_en_d, tx_dat_q, tx_dat_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic        rd_pend_q, rd_pend_d, reg_rd_q;
  logic        reg_wr_q, reg_wr_d;
  logic [15:0] reg_wr_data_q, wr_data_d;
  logic        frame_err_q, err_d;
  logic        mdc_rise, rx_bit;

  assign mdc_rise = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
  assign rx_bit   = mdio_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    is_rd_d    = is_rd_q;
    rd_sh_d    = rd_sh_q;
    tx_en_d    = tx_en_q;
    tx_dat_d   = tx_dat_q;
    reg_addr_d = reg_addr_q;
    rd_pend_d  = 1'b0;
    reg_wr_d   = 1'b0;
    wr_data_d  = reg_wr_data_q;
    err_d      = 1'b0;
    lat_d      = (lat_q != 4'd0) ? lat_q - 4'd1 : 4'd0;
    if (reg_rd_q) lat_d = RD_LAT4;
    if (lat_q == 4'd1) rd_sh_d = reg_rd_data;
    if (mdc_rise) begin
      sh_d  = {sh_q[14:0], rx_bit};
      cnt_d = cnt_q + 6'd1;
      case (state_q)
        S_PRE: begin
          if (rx_bit) cnt_d = (cnt_q == PB) ? PB : cnt_q + 6'd1;
          else if (cnt_q == PB) state_d = S_ST1;
          else cnt_d = 6'd0;
        end
        S_ST1: begin
          cnt_d = 6'd0;
          if (rx_bit) state_d = S_OP;
          else begin
            err_d   = 1'b1;
            state_d = S_PRE;
          end
        end
        S_OP: if (cnt_q[0]) begin
          cnt_d = 6'd0;
          case ({sh_q[0], rx_bit})
            2'b10: begin is_rd_d = 1'b1; state_d = S_ADDR; end
            2'b01: begin is_rd_d = 1'b0; state_d = S_ADDR; end
            default: begin err_d = 1'b1; cnt_d = 6'd28; state_d = S_SKIP; end
          endcase
        end
        S_ADDR: if (cnt_q == 6'd9) begin
          // sh_q[8:4] holds PHYAD; the REGAD LSB is the bit arriving now
          if (sh_q[8:4] == phy_addr) begin
            reg_addr_d = {sh_q[3:0], rx_bit};
            cnt_d      = 6'd0;
            rd_pend_d  = is_rd_q;
            state_d    = is_rd_q ? S_TA1 : S_WTA;
          end else begin
            cnt_d   = 6'd18;
            state_d = S_SKIP;
          end
        end
        S_TA1: state_d = S_TA2;
        S_TA2: begin
          tx_en_d  = 1'b1;
          tx_dat_d = 1'b0;
          cnt_d    = 6'd0;
          state_d  = S_RD;
        end
        S_RD: begin
          tx_dat_d = rd_sh_q[15];
          rd_sh_d  = {rd_sh_q[14:0], 1'b0};
          if (cnt_q == 6'd15) state_d = S_REND;
        end
        S_REND: begin
          tx_en_d  = 1'b0;
          tx_dat_d = 1'b0;
          cnt_d    = 6'd0;
          state_d  = S_PRE;
        end
        S_WTA: if (cnt_q[0]) begin
          if ({sh_q[0], rx_bit} != 2'b10) err_d = 1'b1;
          cnt_d   = 6'd0;
          state_d = S_WD;
        end
        S_WD: if (cnt_q == 6'd15) begin
          reg_wr_d  = 1'b1;
          wr_data_d = {sh_q[14:0], rx_bit};
          cnt_d     = 6'd0;
          state_d   = S_PRE;
        end
        S_SKIP: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            cnt_d   = 6'd0;
            state_d = S_PRE;
          end
        end
        default: begin
          cnt_d   = 6'd0;
          state_d = S_PRE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_sync_q    <= '0;
      mdio_sync_q   <= '0;
      mdc_prev_q    <= 1'b0;
      state_q       <= S_PRE;
      cnt_q         <= 6'd0;
      sh_q          <= 16'd0;
      is_rd_q       <= 1'b0;
      rd_sh_q       <= 16'd0;
      lat_q         <= 4'd0;
      tx_en_q       <= 1'b0;
      tx_dat_q      <= 1'b0;
      reg_addr_q    <= 5'd0;
      rd_pend_q     <= 1'b0;
      reg_rd_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wr_data_q <= 16'd0;
      frame_err_q   <= 1'b0;
    end else begin
      mdc_sync_q    <= {mdc_sync_q[SYNC_STAGES-2:0], mdc};
      mdio_sync_q   <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_rx_data};
      mdc_prev_q    <= mdc_sync_q[SYNC_STAGES-1];
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      is_rd_q       <= is_rd_d;
      rd_sh_q       <= rd_sh_d;
      lat_q         <= lat_d;
      tx_en_q       <= tx_en_d;
      tx_dat_q      <= tx_dat_d;
      reg_addr_q    <= reg_addr_d;
      rd_pend_q     <= rd_pend_d;
      reg_rd_q      <= rd_pend_q;
      reg_wr_q      <= reg_wr_d;
      reg_wr_data_q <= wr_data_d;
      frame_err_q   <= err_d;
    end
  end

  assign mdio_tx_en   = tx_en_q;
  assign mdio_tx_data = tx_dat_q;
  assign reg_addr     = reg_addr_q;
  assign reg_rd       = reg_rd_q;
  assign reg_wr       = reg_wr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: station-side frame generator, register-file emulator and scoreboard.
module tb_mdio_responder;
  localparam int SYNC = 2;
  localparam int RDL  = 2;
  localparam int PBT  = 32;
  localparam int EV_RD = 0, EV_WR = 1, EV_ERR = 2;

  typedef struct { int kind; logic [4:0] a; logic [15:0] d; } ev_t;

  logic        clk = 1'b0;
  logic        rst, mdc, mdio_rx_data;
  logic        mdio_tx_data, mdio_tx_en;
  logic [4:0]  phy_addr, reg_addr;
  logic        reg_rd, reg_wr, frame_err;
  logic [15:0] reg_rd_data, reg_wr_data;

  int checks = 0;
  int errors = 0;
  ev_t evq[$];
  logic [1:0] exp_tx[$];
  logic [1:0] act_tx[$];
  logic [15:0] mem [32];
  logic [4:0] last_addr;

  mdio_responder #(.SYNC_STAGES(SYNC), .RD_LATENCY(RDL), .PREAMBLE_BITS(PBT)) dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_rx_data(mdio_rx_data),
    .mdio_tx_data(mdio_tx_data), .mdio_tx_en(mdio_tx_en), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_rd_data(reg_rd_data),
    .reg_wr(reg_wr), .reg_wr_data(reg_wr_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic void push_ev(input int k, input logic [4:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    evq.push_back(e);
  endfunction

  // Register file behind the responder: valid data only in the capture cycle.
  initial begin
    logic [4:0] a;
    reg_rd_data = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (reg_rd === 1'b1) begin
        a = reg_addr;
        reg_rd_data = ~mem[a];
        repeat (RDL) @(posedge clk);
        #1 reg_rd_data = mem[a];
        @(posedge clk);
        #1 reg_rd_data = ~mem[a];
      end
    end
  end

  // Monitor: strobe events and station-observed bus bits against the scoreboard.
  initial begin
    ev_t e;
    int kind;
    int nb;
    logic [1:0] x, y;
    nb = 0;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b0) begin
        if ((int'(reg_rd) + int'(reg_wr) + int'(frame_err)) > 1) begin
          checks++; errors++;
          $display("FAIL strobe_overlap rd=%b wr=%b err=%b want at most one", reg_rd, reg_wr, frame_err);
        end else if (reg_rd || reg_wr || frame_err) begin
          kind = reg_rd ? EV_RD : (reg_wr ? EV_WR : EV_ERR);
          checks++;
          if (evq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe kind=%0d addr=%h data=%h want none", kind, reg_addr, reg_wr_data);
          end else begin
            e = evq.pop_front();
            if (e.kind != kind || (kind != EV_ERR && reg_addr !== e.a) ||
                (kind == EV_WR && reg_wr_data !== e.d)) begin
              errors++;
              $display("FAIL strobe kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                       kind, reg_addr, reg_wr_data, e.kind, e.a, e.d);
            end
          end
        end
      end
      while (exp_tx.size() > 0 && act_tx.size() > 0) begin
        x = act_tx.pop_front();
        y = exp_tx.pop_front();
        checks++; nb++;
        if (x !== y) begin
          errors++;
          $display("FAIL tx_bit #%0d got en,data=%b want %b", nb, x, y);
        end
      end
    end
  end

  // One MDC period (8 clks); the station samples the bus just before the rise.
  task automatic clk_bit(input bit b, output logic en, output logic d);
    @(negedge clk); mdio_rx_data = b;
    repeat (3) @(negedge clk);
    en = mdio_tx_en; d = mdio_tx_data;
    mdc = 1'b1;
    repeat (4) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; mdc = 1'b0; mdio_rx_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; last_addr = 5'd0;
    @(negedge clk);
  endtask

  task automatic do_frame(input int npre, input bit st0, input logic [1:0] op,
                          input logic [4:0] pa, input logic [4:0] ra, input logic [1:0] ta,
                          input logic [15:0] wd, input int abort_at, input bit chg_phy);
    bit q[$];
    int hdr;
    bit dec, pre_ok;
    logic [15:0] rdw;
    logic en, d;
    logic [1:0] e;
    for (int i = 0; i < npre; i++) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(st0);
    for (int i = 1; i >= 0; i--) q.push_back(op[i]);
    for (int i = 4; i >= 0; i--) q.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    hdr = q.size();
    for (int i = 0; i < 18; i++) begin
      if (op == 2'b01) q.push_back(i < 2 ? ta[1-i] : wd[17-i]);
      else q.push_back(1'b1);
    end
    q.push_back(1'b1); q.push_back(1'b1);

    pre_ok = (npre >= PBT);
    dec = pre_ok && st0 && (op == 2'b10 || op == 2'b01) && (pa == phy_addr);
    if (pre_ok && (!st0 || op == 2'b00 || op == 2'b11)) push_ev(EV_ERR, 5'd0, 16'd0);
    rdw = mem[ra];
    if (dec) begin
      last_addr = ra;
      if (op == 2'b10) push_ev(EV_RD, ra, 16'd0);
      else begin
        if (ta != 2'b10) push_ev(EV_ERR, 5'd0, 16'd0);
        push_ev(EV_WR, ra, wd);
        mem[ra] = wd;
      end
    end

    for (int p = 0; p < q.size(); p++) begin
      if (p + 1 == abort_at) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mdio_tx_en !== 1'b0) begin
          errors++;
          $display("FAIL abort_tx_en got=%b want=0", mdio_tx_en);
        end
        rst = 1'b0;
        last_addr = 5'd0;
        return;
      end
      clk_bit(q[p], en, d);
      if (dec && op == 2'b10 && p + 1 == hdr + 3) e = 2'b10;
      else if (dec && op == 2'b10 && p + 1 >= hdr + 4 && p + 1 <= hdr + 19)
        e = {1'b1, rdw[hdr + 19 - (p + 1)]};
      else e = 2'b00;
      exp_tx.push_back(e);
      act_tx.push_back({en, en & d});
      if (chg_phy && p + 1 == hdr) phy_addr = 5'($urandom_range(0, 31));
    end
    checks++;
    if (reg_addr !== last_addr) begin
      errors++;
      $display("FAIL reg_addr_after_frame got=%h want=%h", reg_addr, last_addr);
    end
  endtask

  initial begin
    int t;
    logic [1:0] op, ta;
    logic [4:0] pa, ra;
    bit st0;
    rst = 1'b1; mdc = 1'b0; mdio_rx_data = 1'b1; phy_addr = 5'h03;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    mem[10] = 16'hBEEF;
    do_reset();
    checks++;
    if ({mdio_tx_en, mdio_tx_data, reg_rd, reg_wr, frame_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=00000", {mdio_tx_en, mdio_tx_data, reg_rd, reg_wr, frame_err});
    end
    checks++;
    if (reg_addr !== 5'd0 || reg_wr_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs got addr=%h wdata=%h want 00 0000", reg_addr, reg_wr_data);
    end

    do_frame(32, 1, 2'b10, 5'h03, 5'h0A, 2'b10, 16'h0, 0, 0);
    do_frame(32, 1, 2'b01, 5'h03, 5'h01, 2'b10, 16'h1234, 0, 0);
    do_frame(32, 1, 2'b10, 5'h07, 5'h05, 2'b10, 16'h0, 0, 0);
    do_frame(32, 1, 2'b10, 5'h03, 5'h1F, 2'b10, 16'h0, 0, 0);
    do_reset();
    do_frame(31, 1, 2'b10, 5'h03, 5'h02, 2'b10, 16'h0, 0, 0);
    do_frame(32, 1, 2'b11, 5'h03, 5'h04, 2'b10, 16'h0, 0, 0);
    do_frame(32, 1, 2'b10, 5'h03, 5'h06, 2'b10, 16'h0, 0, 0);
    do_frame(32, 1, 2'b10, 5'h03, 5'h07, 2'b10, 16'h0, 32 + 14 + 12, 0);
    do_frame(32, 1, 2'b10, 5'h03, 5'h0A, 2'b10, 16'h0, 0, 0);
    do_frame(32, 1, 2'b01, 5'h03, 5'h0C, 2'b11, 16'hA5A5, 0, 0);
    do_frame(32, 0, 2'b10, 5'h03, 5'h0C, 2'b10, 16'h0, 0, 0);
    do_frame(32, 1, 2'b10, 5'h03, 5'h0C, 2'b10, 16'h0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      t   = $urandom_range(0, 5);
      ra  = 5'($urandom_range(0, 31));
      pa  = phy_addr;
      op  = 2'b10;
      ta  = 2'b10;
      st0 = 1'b1;
      case (t)
        1: op = 2'b01;
        2: begin
          op = $urandom_range(0, 1) ? 2'b10 : 2'b01;
          pa = phy_addr ^ 5'($urandom_range(1, 31));
        end
        3: op = $urandom_range(0, 1) ? 2'b11 : 2'b00;
        4: begin st0 = 1'b0; op = 2'($urandom_range(0, 3)); end
        5: begin
          op = 2'b01;
          ta = 2'($urandom_range(0, 2));
          if (ta == 2'b10) ta = 2'b11;
        end
        default: op = 2'b10;
      endcase
      do_frame(32, st0, op, pa, ra, ta, 16'($urandom), 0, ($urandom_range(0, 2) == 0));
    end

    repeat (40) @(negedge clk);
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes pending=%0d want 0", evq.size());
    end
    checks++;
    if (exp_tx.size() != act_tx.size()) begin
      errors++;
      $display("FAIL tx_queue_balance got=%0d want=%0d", act_tx.size(), exp_tx.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- MDIO management-frame responder (IEEE 802.3 clause 22): the PHY-side counterpart of the management MDIO transceiver.
- Oversamples MDC/MDIO in the fabric clock, decodes read/write frames addressed to its PHY address, and exposes a simple register strobe interface.
- Used to emulate PHY register space behind the management MDIO bus (front-panel/expansion boards, loopback test of the MDIO master).

Parameters:
SYNC_STAGES, 2, synchronizer depth on mdc and mdio_rx_data (min 2)
RD_LATENCY, 2, clk cycles from reg_rd pulse to reg_rd_data capture (1..8)
PREAMBLE_BITS, 32, consecutive 1s required before a start sequence is accepted (1..32)

Ports:
clk  input  1  fabric clock; must be at least 8x MDC frequency
rst  input  1  synchronous active-high reset
mdc  input  1  MDC from station, asynchronous to clk
mdio_rx_data  input  1  MDIO pad input, asynchronous
mdio_tx_data  output  1  MDIO drive value
mdio_tx_en  output  1  MDIO output enable to bidirectional buffer
phy_addr  input  5  this responder's PHY address, quasi-static
reg_addr  output  5  register address of current/last matching frame
reg_rd  output  1  one-cycle read strobe
reg_rd_data  input  16  read data, captured RD_LATENCY cycles after reg_rd
reg_wr  output  1  one-cycle write strobe
reg_wr_data  output  16  write data, valid with reg_wr, held until next write
frame_err  output  1  one-cycle pulse on malformed frame

Behaviour:
- Reset: all outputs 0; state PREAMBLE, preamble count 0, sync chains 0. A spurious MDC rising edge after reset (mdc already high) is harmless: it samples idle-high MDIO as preamble.
- mdc and mdio_rx_data pass through SYNC_STAGES flops. An MDC rise is sync_out==1 && previous==0. Every bit is sampled and every drive change happens only on the clk cycle of a detected MDC rise ("edge").
- PREAMBLE: on each edge, a sampled 1 increments the count, saturating at PREAMBLE_BITS. A sampled 0 with count==PREAMBLE_BITS goes to ST1; a 0 with a lower count clears the count.
- ST1: a sampled 1 goes to OP. A sampled 0 pulses frame_err and returns to PREAMBLE with count 0.
- OP (2 bits, MSB first): 10 = read, 01 = write. 00 or 11 pulses frame_err and goes to SKIP for the remaining 28 bits.
- PHYAD (5 bits) then REGAD (5 bits), both shifted MSB first. At the REGAD last-bit edge:
  - phyad != phy_addr: go to SKIP for 18 edges with tx_en held 0, then PREAMBLE with count 0. reg_addr is not updated.
  - phyad matches: reg_addr <= regad on the same edge; go to TA.
- Read, matching frame:
  - reg_rd pulses on the cycle after reg_addr updates.
  - reg_rd_data is captured into the shift register exactly RD_LATENCY cycles after the reg_rd pulse.
  - TA first edge: tx_en stays 0.
  - TA second edge: tx_en=1, tx_data=0.
  - Next 16 edges: drive data bits 15..0.
  - Edge after bit 0: tx_en=0 and tx_data=0, then PREAMBLE with count 0.
- Write, matching frame:
  - The 2 TA bits are sampled; a value other than 10 pulses frame_err, but the frame still completes.
  - The 16 data bits are shifted MSB first.
  - On the cycle after the 16th edge: reg_wr_data updates and reg_wr pulses for one cycle. Then PREAMBLE with count 0.
- Bus contention guard: tx_en is never 1 outside the TA2..D0 window of a matching read.
- rst asserted mid-frame: immediate return to reset state on the next clk. A mid-read abort drops tx_en that cycle; no strobe is emitted for the aborted frame.
- phy_addr changing mid-frame: the comparison uses the value at the REGAD last-bit edge.
- reg_rd and reg_wr are never asserted in the same cycle.

Test Plan:
- phy_addr=5'h03; 32x1, 01, 10, 00011, 01010, then idle-high MDC clocks; reg_rd_data=16'hBEEF driven RD_LATENCY cycles after reg_rd -> single reg_rd with reg_addr=5'h0A; tx_en rises on TA second edge with 0; the next 16 bits read 1011111011101111; tx_en falls after bit 0.
- phy_addr=5'h03; write frame, PHYAD 00011, REGAD 00001, TA 10, data 16'h1234 -> one reg_wr pulse, reg_addr=5'h01, reg_wr_data=16'h1234; tx_en stays 0 throughout.
- Read frame to PHYAD 00111 with phy_addr=3 -> no reg_rd, tx_en 0 for the whole frame, reg_addr unchanged; an immediately following valid read to PHYAD 3 is decoded normally.
- Preamble of 31 ones then 01 -> no decode, no strobes, no frame_err. OP=11 after a full preamble -> one frame_err pulse, 28 bits skipped, no strobes.
- Back-to-back reads at MDC = clk/8, with rst asserted at data bit 7 of the second read -> tx_en drops the next clk; no further strobes; the next full frame decodes normally.
- Write frame with TA=11 and data 16'hA5A5 -> one frame_err pulse, then reg_wr with 16'hA5A5.
